// File: rtl/scan_ctrl_pkg.sv
// Shared widths, output-register bundle and helpers for the display scan controller.
// The downstream 3-to-8 decoder is sized from the same SEL_W.
package scan_pkg;

   localparam int SEL_W      = 3;
   localparam int MAX_DIGITS = 8;
   localparam int NIBBLE_W   = 4;
   localparam int BUS_W      = MAX_DIGITS * NIBBLE_W;

   typedef logic [SEL_W-1:0]    sel_t;
   typedef logic [NIBBLE_W-1:0] nibble_t;

   // Everything that leaves the block is registered together in one bundle.
   typedef struct packed {
      sel_t    sel;
      nibble_t digit;
      logic    enable;
      logic    frame_done;
   } scan_out_t;

   function automatic nibble_t nibble_at(input logic [BUS_W-1:0] bus, input sel_t idx);
      return bus[idx*NIBBLE_W +: NIBBLE_W];
   endfunction

endpackage

// File: rtl/scan_ctrl_if.sv
// Bundle of the scan controller's control inputs and decoder-facing outputs.
// master drives the controls (system side), slave is the scan controller itself.
interface scan_ctrl_if;
   import scan_pkg::*;

   logic                  run;
   logic                  step;
   logic [MAX_DIGITS-1:0] blank_mask;
   logic [BUS_W-1:0]      digit_bus;
   sel_t                  Data_in;
   logic                  Enable;
   nibble_t               digit_out;
   logic                  frame_done;

   modport master (
      output run, step, blank_mask, digit_bus,
      input  Data_in, Enable, digit_out, frame_done
   );

   modport slave (
      input  run, step, blank_mask, digit_bus,
      output Data_in, Enable, digit_out, frame_done
   );

endinterface

// File: rtl/scan_ctrl_prescaler.sv
// Slot-rate tick generator: free-running divider while run=1, one tick per rising
// edge of step while run=0.
module scan_prescaler #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   input  logic step_i,
   output logic tick_o
);

   localparam int PCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);

   logic [PCNT_W-1:0] pcnt_q;
   logic [PCNT_W-1:0] pcnt_d;
   logic              step_d_q;
   logic              step_rise;

   always_comb begin
      step_rise = step_i & ~step_d_q;
      tick_o    = 1'b0;
      pcnt_d    = '0;
      if (run_i) begin
         tick_o = (pcnt_q == PCNT_LAST);
         pcnt_d = tick_o ? '0 : pcnt_q + PCNT_W'(1);
      end else begin
         // Holding: divider parked at 0 so a later run restarts a full slot.
         tick_o = step_rise;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q   <= '0;
         step_d_q <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         step_d_q <= step_i;
      end
   end

endmodule

// File: rtl/scan_ctrl.sv
// Multiplexed-display scan controller: advances the digit select, applies blanking
// and post-switch dead time, and presents the matching nibble to the decoder.
module scan_ctrl
   import scan_pkg::*;
#(
   parameter int CLK_DIV    = 50000,
   parameter int NUM_DIGITS = 8,
   parameter int DEAD_CYC   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   scan_ctrl_if.slave  scan
);

   generate
      if (CLK_DIV < 2 || NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS ||
          DEAD_CYC < 0 || DEAD_CYC > CLK_DIV - 1) begin : g_bad_params
         $fatal(1, "scan_ctrl: parameter out of range");
      end
   endgenerate

   localparam int   DCNT_W   = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
   localparam sel_t SEL_LAST = sel_t'(NUM_DIGITS - 1);

   logic              tick;
   sel_t              sel_nxt;
   logic [DCNT_W-1:0] dcnt_q;
   logic [DCNT_W-1:0] dcnt_d;
   scan_out_t         out_q;
   scan_out_t         out_d;

   scan_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .run_i  (scan.run),
      .step_i (scan.step),
      .tick_o (tick)
   );

   // The registered select doubles as the current scan position.
   always_comb begin
      sel_nxt = out_q.sel;
      if (tick) begin
         sel_nxt = (out_q.sel == SEL_LAST) ? '0 : out_q.sel + sel_t'(1);
      end

      if (sel_nxt != out_q.sel) begin
         dcnt_d = DCNT_W'(DEAD_CYC);
      end else if (dcnt_q != '0) begin
         dcnt_d = dcnt_q - DCNT_W'(1);
      end else begin
         dcnt_d = '0;
      end

      // A single-digit scan never changes select, so it never enters dead time.
      out_d.sel        = sel_nxt;
      out_d.digit      = nibble_at(scan.digit_bus, sel_nxt);
      out_d.enable     = ~scan.blank_mask[sel_nxt] & (dcnt_d == '0);
      out_d.frame_done = tick & (sel_nxt == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_q <= '0;
         out_q  <= '0;
      end else begin
         dcnt_q <= dcnt_d;
         out_q  <= out_d;
      end
   end

   assign scan.Data_in    = out_q.sel;
   assign scan.digit_out  = out_q.digit;
   assign scan.Enable     = out_q.enable;
   assign scan.frame_done = out_q.frame_done;

endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

Multiplexed-display scan controller sitting directly upstream of the 3-to-8 `decoder` stage. It generates a slowly advancing 3-bit digit select and an enable that drive the decoder's `Data_in`/`Enable`, plus the 4-bit digit value aligned to that select. It supports per-digit blanking, anti-ghosting dead time, run/hold with single-step, and a once-per-frame strobe.

## Interface
- `CLK_DIV`, default 50000: `clk` cycles per scan slot; legal range ≥ 2.
- `NUM_DIGITS`, default 8: digits scanned; legal range 1..8.
- `DEAD_CYC`, default 2: cycles `Enable_out` is held low after each select change; legal range 0..`CLK_DIV`-1.
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: 1 = free-running scan; 0 = hold on current digit.
- `step` in 1: level; its rising edge advances one digit while `run`=0.
- `blank_mask` in 8: bit i = 1 blanks digit i.
- `digit_bus` in 32: nibble i is `digit_bus[4i+3:4i]`.
- `Data_in` out 3: digit select to the decoder.
- `Enable` out 1: decoder enable.
- `digit_out` out 4: nibble of the currently selected digit.
- `frame_done` out 1: one-cycle pulse when the select wraps to 0.

## Operation
- Prescaler `pcnt` counts 0..`CLK_DIV`-1 while `run`=1; `tick` = (`pcnt`==`CLK_DIV`-1) & `run`; it wraps to 0 on `tick`. While `run`=0, `pcnt` is forced to 0.
- Step edge detect: `step_d` is a register of `step`. `step_rise` = `step` & ~`step_d`. While `run`=0, `step_rise` produces `tick` in the same cycle. `step` is ignored while `run`=1. Holding `step` high gives exactly one advance.
- `sel_nxt` = `tick` ? (`sel`==`NUM_DIGITS`-1 ? 0 : `sel`+1) : `sel`.
- Dead-time counter `dcnt` loads `DEAD_CYC` whenever `sel_nxt` ≠ `sel`; otherwise it decrements to 0 and saturates there.
- All outputs are registered every cycle from `sel_nxt`:
  - `Data_in` ← `sel_nxt`
  - `digit_out` ← nibble `sel_nxt` of `digit_bus`
  - `Enable` ← ~`blank_mask[sel_nxt]` & (dead-time expired)
  - `frame_done` ← `tick` & (`sel_nxt`==0)
- `blank_mask` and `digit_bus` changes reach the outputs one cycle later, even without a tick.
- `NUM_DIGITS`=1: `Data_in` stays 0 and `frame_done` pulses on every tick. When `DEAD_CYC`=0, `Enable` is never gated.
- Selects ≥ `NUM_DIGITS` are never produced.

## Timing
- Reset (asynchronous, immediate, including mid-scan): `Data_in`=0, `Enable`=0, `digit_out`=0, `frame_done`=0, `pcnt`=0, `dcnt`=0, `step_d`=0.
- First cycle after reset release: `Enable` = ~`blank_mask[0]`.
- Free-run: the select changes every `CLK_DIV` cycles, with the output change registered the cycle after `tick`. Full frame = `NUM_DIGITS`×`CLK_DIV` cycles.
- After a select change, `Enable` is 0 for `DEAD_CYC` cycles, then follows the blank mask.
- Step: `step` rises in cycle n; `Data_in` changes at n+1.
- `run` falling mid-slot: the select holds and `pcnt` clears. After `run` rises again, the next tick comes a full `CLK_DIV` cycles later.
- `run` falling in the same cycle as `pcnt`==`CLK_DIV`-1: no tick occurs.

## Structure
- Shared header/package `scan_pkg` holds `SEL_W`=3, `MAX_DIGITS`=8 and `NIBBLE_W`=4. The `decoder` instantiation uses the same `SEL_W`.
- Sub-module `scan_prescaler` contains `pcnt`, the `step` edge detect and the `tick` output. The top level holds `sel`, `dcnt` and the output registers.
- Out-of-range parameters are rejected at elaboration.

## Test plan
- Reset/hold: `rst_n`=0 for 3 cycles, then release with `run`=0 and `blank_mask`=0x00 → `Data_in`=0, `Enable`=1 after 1 cycle, and no advance over 50 cycles.
- Free scan with `CLK_DIV`=4, `NUM_DIGITS`=8, `DEAD_CYC`=1, `run`=1 → `Data_in` steps 0..7 every 4 cycles, `Enable` low 1 cycle per slot, `frame_done` pulses every 32 cycles as `Data_in` returns to 0.
- Blanking/data: `blank_mask`=0x0A, `digit_bus`=0x76543210 → `Enable` is never 1 while `Data_in`=1 or 3, and `digit_out` equals `Data_in` in every slot.
- Wrap limit with `NUM_DIGITS`=5 → `Data_in` sequence 0,1,2,3,4,0; `frame_done` is high only on the 4→0 transition.
- Single-step: `run`=0, `step` held high for 10 cycles, then pulsed twice → exactly 3 advances total. `step` pulses while `run`=1 cause no extra advance.
- Async reset mid-scan at `Data_in`=5 → all outputs are 0 within the same cycle, and scanning restarts from 0.
